// File: rtl/conv_frame_sequencer_if.sv
// Valid/ready pixel stream between the frame sequencer and the convolution.
// Ports: data (W), valid, ready; master drives data/valid, slave drives ready.
interface conv_frame_sequencer_if #(
  parameter int W = 12
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/conv_frame_sequencer.sv
// Frame controller: streams a frame from source BRAM into the convolution,
// appends flush pixels, writes results to destination BRAM, pulses done.
// Ports: clk, reset (async high), start, mode_sel -> filter_mode, busy, done,
// rd_addr/rd_data (source BRAM), conv_in (master), conv_out (slave),
// wr_addr/wr_data/wr_en (destination BRAM).
module conv_frame_sequencer #(
  parameter int W       = 12,
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 240,
  parameter int FLUSH_N = 2,
  parameter int ADDR_W  = $clog2(IMG_W*IMG_H)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             mode_sel,
  output logic [2:0]             filter_mode,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      rd_addr,
  input  logic [W-1:0]           rd_data,
  conv_frame_sequencer_if.master conv_in,
  conv_frame_sequencer_if.slave  conv_out,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [W-1:0]           wr_data,
  output logic                   wr_en
);
  localparam int N  = IMG_W*IMG_H;
  localparam int CW = $clog2(N+FLUSH_N+1);
  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW-1:0] END_C = CW'(N+FLUSH_N);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] wr_nxt;
  logic          vld;
  logic          fresh;
  logic [W-1:0]  hold;
  logic [W-1:0]  slot_data;
  logic          slot_free;
  logic          rd_issue;
  logic          fl_issue;
  logic          accept;

  // The slot shows BRAM data directly in the cycle after the read;
  // if it stalls there, the value is captured into hold because the
  // BRAM output moves on with the next address.
  assign slot_data = fresh ? rd_data : hold;
  assign slot_free = !vld || conv_in.ready;

  assign conv_in.valid  = vld;
  assign conv_in.data   = slot_data;
  assign conv_out.ready = 1'b1;

  assign busy    = (state == FEED) || (state == FLUSH);
  assign done    = (state == DONE);
  assign rd_addr = (state == FEED) ? rd_cnt[ADDR_W-1:0] : '0;
  assign wr_en   = conv_out.valid && busy && (wr_cnt < N_C);
  assign wr_addr = (wr_cnt < N_C) ? wr_cnt[ADDR_W-1:0] : '0;
  assign wr_data = busy ? conv_out.data : '0;
  assign wr_nxt  = wr_cnt + CW'(wr_en);
  assign accept  = (state == IDLE) && start;

  always_comb begin
    state_n  = state;
    rd_issue = 1'b0;
    fl_issue = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = FEED;
      end
      FEED: begin
        if (slot_free) begin
          rd_issue = 1'b1;
          if (rd_cnt == N_C - ONE) state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free && rd_cnt != END_C) fl_issue = 1'b1;
        // Finish once the last flush beat has left the slot and the
        // final result write lands this cycle (or already has).
        if (slot_free && rd_cnt == END_C && wr_nxt == N_C)
          state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      filter_mode <= 3'd0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      vld         <= 1'b0;
      fresh       <= 1'b0;
      hold        <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        filter_mode <= mode_sel;
        rd_cnt      <= '0;
        wr_cnt      <= '0;
      end else begin
        if (rd_issue || fl_issue) rd_cnt <= rd_cnt + ONE;
        wr_cnt <= wr_nxt;
      end
      hold <= fl_issue ? '0 : slot_data;
      if (slot_free) begin
        vld   <= rd_issue || fl_issue;
        fresh <= rd_issue;
      end else begin
        fresh <= 1'b0;
      end
    end
  end
endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the 3x3 convolution stage in the VGA image path. On a start pulse it latches the filter mode and streams one full frame from the source frame-buffer BRAM into the convolution's input dstream. It then appends flush pixels so the convolution pipeline drains, and writes every result beat into the destination frame buffer. It signals completion with a one-cycle done pulse, so the VGA/top-level logic can run one filtered frame per start.

## Interface
Parameters:
- W, 12, pixel width; must equal the convolution's W.
- IMG_W, 320, frame width in pixels.
- IMG_H, 240, frame height in pixels.
- FLUSH_N, 2, zero pixels appended after the frame to drain the convolution pipeline.
- ADDR_W, $clog2(IMG_W*IMG_H), frame-buffer address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- mode_sel  in  3  requested filter mode.
- filter_mode  out  3  mode driven to the convolution; latched at accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last result write.
- rd_addr  out  ADDR_W  source BRAM read address.
- rd_data  in  W  source BRAM read data; valid 1 cycle after rd_addr.
- conv_in  dstream.out  W  pixel stream to the convolution (data/valid/ready).
- conv_out  dstream.in  W  result stream from the convolution; ready tied high by this block.
- wr_addr  out  ADDR_W  destination BRAM write address.
- wr_data  out  W  destination write data (= conv_out.data).
- wr_en  out  1  destination write strobe.

## Operation
- N = IMG_W*IMG_H. Counters: rd_cnt (0..N+FLUSH_N), wr_cnt (0..N), each $clog2(N+FLUSH_N+1) bits wide.
- States:
  - IDLE: accepts start, latches mode_sel into filter_mode, clears both counters, moves to FEED.
  - FEED: issues a read when the output slot is free, that is when !conv_in.valid, or conv_in.ready is high this cycle. rd_addr = rd_cnt, and rd_cnt increments on each issued read.
    - Read data enters the output slot one cycle after the read is issued.
    - Moves to FLUSH when rd_cnt reaches N.
  - FLUSH: presents FLUSH_N beats with data 0 using the same slot rule; no BRAM reads are issued. After the last flush beat is accepted, it holds until wr_cnt reaches N.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Slot rule: conv_in.data/valid are held stable while conv_in.valid && !conv_in.ready. They are never retracted.
- Write side: wr_en = conv_out.valid && busy && wr_cnt < N. wr_addr = wr_cnt, wr_data = conv_out.data, and wr_cnt increments on each write. Result beats arriving after wr_cnt = N are dropped.
- filter_mode holds its latched value through IDLE until the next accepted start. mode_sel changes mid-frame are ignored.
- start while busy is ignored; it is not queued.
- rd_addr and wr_addr never exceed N-1. Counters do not wrap; each frame restarts them at 0.

## Timing
- Reset values: filter_mode=0, busy=0, done=0, rd_addr=0, conv_in.valid=0, conv_in.data=0, wr_en=0, wr_addr=0, wr_data=0; state=IDLE.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. No partial done is produced, and in-flight BRAM data is discarded.
- start sampled high in IDLE at edge t:
  - busy=1 and filter_mode valid from t+1.
  - First read (rd_addr=0) is presented at t+1.
  - conv_in.valid rises at t+2.
- With conv_in.ready held high, pixels and then flush beats are accepted on consecutive cycles, for N+FLUSH_N beats with no bubbles.
- Back-pressure: conv_in.ready low stalls rd_addr/rd_cnt. At most one read is outstanding, so no data is lost.
- done pulses on the cycle after the write that takes wr_cnt to N. busy falls in the same cycle done rises.
- start high in the same cycle done is high is ignored. A new start is accepted from the first IDLE cycle after done.

## Test plan
- Nominal frame: IMG_W=4, IMG_H=3, FLUSH_N=2, ready=1, identity kernel, source[i]=i+1, start pulse.
  - Exactly 14 accepted conv_in beats: 1..12 followed by 0,0.
  - Exactly 12 writes, addr 0..11.
  - One done pulse; busy high for the whole run.
- Back-pressure: toggle conv_in.ready 1,0,0,1 repeatedly.
  - Accepted beat sequence is identical to the nominal run, with no duplicates or skips.
  - rd_addr is frozen while stalled.
- Mode latch: start with mode_sel=3, then change mode_sel to 4 mid-frame.
  - filter_mode stays 3 until done.
  - The next start latches 4.
- start while busy: pulse start at beats 5 and 12 of a frame.
  - No restart, counters unaffected, single done.
  - A start on the first cycle after done is accepted.
- Reset mid-frame: assert reset at beat 6.
  - All outputs go to reset values immediately, with no done.
  - After deassert and start, a full frame completes normally from addr 0.
- Excess results: drive conv_out.valid for 3 extra beats after the 12th write.
  - wr_en stays 0 for those beats; wr_addr never reaches 12.
